// File: rtl/pong_ball_ctrl.sv
// Pong ball motion controller: serve delay, one-pixel-per-tick motion,
// wall/paddle bounces, miss detection and single-cycle score pulses.
module pong_ball_ctrl #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned PADDLE_L_X  = 16,
  parameter int unsigned PADDLE_R_X  = 616,
  parameter int unsigned SERVE_TICKS = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       in_play,
  output logic       score_l,
  output logic       score_r
);

  localparam logic [9:0] CX         = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] CY         = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0] X_MAX      = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0] Y_MAX      = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0] X_L_FACE   = 10'(PADDLE_L_X + PADDLE_W);
  localparam logic [5:0] SERVE_LAST = 6'(SERVE_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StServe, StPlay, StScored} state_e;

  state_e      r_state, w_state_d;
  logic [9:0]  r_x, w_x_d, r_y, w_y_d;
  logic        r_dx, w_dx_d, r_dy, w_dy_d;
  logic [5:0]  r_cnt, w_cnt_d;
  logic        r_in_play, w_in_play_d;
  logic        r_score_l, w_score_l_d;
  logic        r_score_r, w_score_r_d;

  logic [10:0] w_y_top, w_y_bot, w_pl, w_pr;
  logic        w_ovl_l, w_ovl_r, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic [9:0]  w_y_mv;
  logic        w_dy_mv;

  // 11-bit compares so y+BALL_SIZE and paddle_y+PADDLE_H never wrap
  assign w_y_top  = {1'b0, r_y};
  assign w_y_bot  = w_y_top + 11'(BALL_SIZE);
  assign w_pl     = {1'b0, paddle_l_y};
  assign w_pr     = {1'b0, paddle_r_y};
  assign w_ovl_l  = (w_y_bot > w_pl) && (w_y_top < w_pl + 11'(PADDLE_H));
  assign w_ovl_r  = (w_y_bot > w_pr) && (w_y_top < w_pr + 11'(PADDLE_H));
  assign w_hit_l  = !r_dx && (r_x == X_L_FACE) && w_ovl_l;
  assign w_hit_r  = r_dx && (({1'b0, r_x} + 11'(BALL_SIZE)) == 11'(PADDLE_R_X)) && w_ovl_r;
  assign w_miss_l = !r_dx && (r_x == 10'd0);
  assign w_miss_r = r_dx && (r_x == X_MAX);

  always_comb begin
    w_y_mv  = r_dy ? r_y + 10'd1 : r_y - 10'd1;
    w_dy_mv = r_dy;
    if (!r_dy && (r_y == 10'd0)) begin
      w_y_mv  = 10'd1;
      w_dy_mv = 1'b1;
    end else if (r_dy && (r_y == Y_MAX)) begin
      w_y_mv  = r_y - 10'd1;
      w_dy_mv = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_x       <= CX;
      r_y       <= CY;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_cnt     <= 6'd0;
      r_in_play <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_x       <= w_x_d;
      r_y       <= w_y_d;
      r_dx      <= w_dx_d;
      r_dy      <= w_dy_d;
      r_cnt     <= w_cnt_d;
      r_in_play <= w_in_play_d;
      r_score_l <= w_score_l_d;
      r_score_r <= w_score_r_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_dx_d    = r_dx;
    w_dy_d    = r_dy;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: if (start) w_state_d = StServe;
      StServe: begin
        if (tick) begin
          if (r_cnt == SERVE_LAST) begin
            w_cnt_d   = 6'd0;
            w_state_d = StPlay;
          end else begin
            w_cnt_d = r_cnt + 6'd1;
          end
        end
      end
      StPlay: begin
        if (tick) begin
          if (!w_hit_l && !w_hit_r && (w_miss_l || w_miss_r)) begin
            // Serve heads toward the conceding player; dy survives the miss
            w_state_d = StScored;
            w_x_d     = CX;
            w_y_d     = CY;
            w_dx_d    = w_miss_r;
          end else begin
            w_y_d  = w_y_mv;
            w_dy_d = w_dy_mv;
            if (w_hit_l) begin
              w_dx_d = 1'b1;
              w_x_d  = r_x + 10'd1;
            end else if (w_hit_r) begin
              w_dx_d = 1'b0;
              w_x_d  = r_x - 10'd1;
            end else begin
              w_x_d = r_dx ? r_x + 10'd1 : r_x - 10'd1;
            end
          end
        end
      end
      StScored: w_state_d = StServe;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_in_play_d = (w_state_d == StPlay);
    w_score_l_d = (w_state_d == StScored) && w_dx_d;
    w_score_r_d = (w_state_d == StScored) && !w_dx_d;
  end

  assign ball_x  = r_x;
  assign ball_y  = r_y;
  assign in_play = r_in_play;
  assign score_l = r_score_l;
  assign score_r = r_score_r;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl: a behavioural ball model checked every cycle,
// plus hand-computed position/pulse expectations along a scripted rally.
module tb_pong_ball_ctrl;

  localparam int H_RES = 640, V_RES = 480, BALL = 8, PW = 8, PH = 64;
  localparam int PLX = 16, PRX = 616, SERVE = 60;
  localparam int CX = (H_RES - BALL) / 2, CY = (V_RES - BALL) / 2;
  localparam int MIDLE = 0, MSERVE = 1, MPLAY = 2, MSCORED = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] paddle_l_y = 10'd400;
  logic [9:0] paddle_r_y = 10'd400;
  logic [9:0] ball_x, ball_y;
  logic       in_play, score_l, score_r;

  int n_total = 0;
  int n_bad   = 0;

  pong_ball_ctrl dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .paddle_l_y(paddle_l_y),
    .paddle_r_y(paddle_r_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .in_play   (in_play),
    .score_l   (score_l),
    .score_r   (score_r)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integer positions, reflection at the walls
  int m_state = MIDLE, m_ticks = 0, m_x = CX, m_y = CY, m_dx = 1, m_dy = 1;
  bit m_in_play = 0, m_sl = 0, m_sr = 0;

  function automatic bit overlaps(int y, int p);
    return (y + BALL > p) && (y < p + PH);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = MIDLE; m_ticks = 0; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
      m_sl = 0; m_sr = 0;
    end else begin
      int nx, ny, ndx, ndy;
      m_sl = 0; m_sr = 0;
      case (m_state)
        MIDLE:   if (start) m_state = MSERVE;
        MSERVE: begin
          if (tick) begin
            m_ticks++;
            if (m_ticks == SERVE) begin m_ticks = 0; m_state = MPLAY; end
          end
        end
        MPLAY: begin
          if (tick) begin
            ndy = m_dy;
            ny  = m_y + (m_dy ? 1 : -1);
            if (ny < 0) begin ny = 1; ndy = 1; end
            else if (ny > V_RES - BALL) begin ny = m_y - 1; ndy = 0; end
            ndx = m_dx;
            nx  = m_x + (m_dx ? 1 : -1);
            if (m_dx == 0 && m_x == PLX + PW && overlaps(m_y, int'(paddle_l_y))) begin
              nx = m_x + 1; ndx = 1;
            end else if (m_dx == 1 && m_x + BALL == PRX && overlaps(m_y, int'(paddle_r_y))) begin
              nx = m_x - 1; ndx = 0;
            end
            if (nx < 0 || nx > H_RES - BALL) begin
              m_sr = (nx < 0); m_sl = (nx >= 0);
              m_dx = m_sl ? 1 : 0;
              m_x = CX; m_y = CY; m_state = MSCORED;
            end else begin
              m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
            end
          end
        end
        default: m_state = MSERVE;
      endcase
    end
    m_in_play = (m_state == MPLAY);
  end

  always @(negedge clk) begin
    n_total++;
    if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || in_play !== m_in_play ||
        score_l !== m_sl || score_r !== m_sr) begin
      n_bad++;
      $display("FAIL model t=%0t got x=%0d y=%0d ip=%b sl=%b sr=%b want x=%0d y=%0d ip=%b sl=%b sr=%b",
               $time, ball_x, ball_y, in_play, score_l, score_r, m_x, m_y, m_in_play, m_sl, m_sr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic pos(input string name, input int x, input int y);
    chk({name, ".x"}, int'(ball_x), x);
    chk({name, ".y"}, int'(ball_y), y);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    #12;
    pos("in_reset", CX, CY);
    chk("in_reset.in_play", int'(in_play), 0);
    #11 reset = 1'b1;

    ticks(5);
    pos("idle", 316, 236);
    chk("idle.in_play", int'(in_play), 0);
    chk("idle.score", int'(score_l | score_r), 0);

    // Round 1: serve right, bottom bounce, right paddle hit, left miss
    pulse_start();
    ticks(59);
    chk("serve59.in_play", int'(in_play), 0);
    ticks(1);
    chk("serve60.in_play", int'(in_play), 1);
    pos("serve60", 316, 236);
    ticks(1);
    pos("first_move", 317, 237);
    ticks(235);
    pos("at_bottom", 552, 472);
    ticks(1);
    pos("bottom_bounce", 553, 471);
    ticks(55);
    pos("at_r_paddle", 608, 416);
    ticks(1);
    pos("r_paddle_hit", 607, 415);
    ticks(607);
    pos("at_left_edge", 0, 192);
    ticks(1);
    chk("left_miss.score_r", int'(score_r), 1);
    chk("left_miss.score_l", int'(score_l), 0);
    chk("left_miss.in_play", int'(in_play), 0);
    pos("left_miss", 316, 236);
    @(posedge clk); #1;
    chk("after_miss.score_r", int'(score_r), 0);

    // Round 2: serve left, left paddle hit, right paddle miss
    paddle_r_y = 10'd200;
    ticks(60);
    chk("serve2.in_play", int'(in_play), 1);
    ticks(292);
    pos("at_l_paddle", 24, 416);
    ticks(1);
    pos("l_paddle_hit", 25, 415);
    ticks(583);
    pos("at_r_face2", 608, 168);
    ticks(1);
    pos("r_paddle_pass", 609, 169);
    ticks(23);
    pos("at_right_edge", 632, 192);
    ticks(1);
    chk("right_miss.score_l", int'(score_l), 1);
    chk("right_miss.score_r", int'(score_r), 0);
    #1 reset = 1'b0;
    #1;
    chk("reset_in_scored.score_l", int'(score_l), 0);
    chk("reset_in_scored.in_play", int'(in_play), 0);
    pos("reset_in_scored", 316, 236);
    #1 reset = 1'b1;

    // Round 3: mid-play asynchronous reset
    pulse_start();
    ticks(60);
    ticks(84);
    pos("round3", 400, 320);
    chk("round3.in_play", int'(in_play), 1);
    #2 reset = 1'b0;
    #1;
    pos("mid_reset", 316, 236);
    chk("mid_reset.in_play", int'(in_play), 0);
    chk("mid_reset.score", int'(score_l | score_r), 0);
    #1 reset = 1'b1;
    ticks(2);
    pos("post_reset_idle", 316, 236);
    chk("post_reset_idle.in_play", int'(in_play), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL timeout got=running want=finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
